// File: rtl/demux_1_to_4_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1_to_4_reg_pkg
//  Purpose  : Shared constants and helpers for the registered 1-to-4 demux.
//             NUM_OUT / SEL_W size the channel fan-out and the select field;
//             CH_A..CH_D name the channel indices (bit position in out_valid /
//             out_ready). sel_onehot() turns a select code into a one-hot
//             channel mask.
//  Revision : 1.0 - initial release
// ============================================================================
package demux_1_to_4_reg_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;
  localparam int CH_D = 3;

  typedef enum logic [SEL_W-1:0] {
    SEL_A = 2'd0,
    SEL_B = 2'd1,
    SEL_C = 2'd2,
    SEL_D = 2'd3
  } sel_e;

  // One-hot channel mask for a destination select code.
  function automatic logic [NUM_OUT-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_OUT-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_1_to_4_reg_slot.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1_to_4_reg_slot
//  Purpose  : One output channel of the demux: a one-entry register slice with
//             valid/ready handshake plus a free-running wrap counter of the
//             beats loaded into it.
//  Ports    : clk, rst   - clock, synchronous active-high reset
//             ld         - load d this cycle (beat accepted for this channel)
//             d          - data word to load
//             rdy        - downstream consumer takes the held beat
//             q, vld     - held data word and its valid flag
//             cnt        - beats loaded since reset (wraps, no saturation)
//  Revision : 1.0 - initial release
// ============================================================================
module demux_1_to_4_reg_slot #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             rdy,
  output logic [WIDTH-1:0] q,
  output logic             vld,
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] r_q;
  logic             r_vld;
  logic [CNT_W-1:0] r_cnt;

  // A load takes priority over a drain: when the consumer takes the old beat
  // in the same cycle a new one arrives, the slot simply stays valid with the
  // new word. A drain only clears valid; the data register keeps its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      r_vld <= 1'b0;
      r_cnt <= '0;
    end else if (ld) begin
      r_q   <= d;
      r_vld <= 1'b1;
      r_cnt <= r_cnt + 1'b1;
    end else if (r_vld && rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign q   = r_q;
  assign vld = r_vld;
  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/demux_1_to_4_reg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1_to_4_reg
//  Purpose  : Registered 1-to-4 demultiplexer. Each input beat (in_data,
//             in_sel) is steered into one of four independent one-entry
//             output slots (a/b/c/d), each with its own valid/ready handshake
//             and beat counter.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             in_data/in_sel     - input word and destination (00=a .. 11=d)
//             in_valid/in_ready  - input handshake
//             out_a..out_d       - registered channel data
//             out_valid[3:0]     - per-channel valid (bit0=a .. bit3=d)
//             out_ready[3:0]     - per-channel consumer ready
//             cnt_a..cnt_d       - beats accepted per channel since reset
//  Revision : 1.0 - initial release
// ============================================================================
module demux_1_to_4_reg
  import demux_1_to_4_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic [WIDTH-1:0]   out_c,
  output logic [WIDTH-1:0]   out_d,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [CNT_W-1:0]   cnt_a,
  output logic [CNT_W-1:0]   cnt_b,
  output logic [CNT_W-1:0]   cnt_c,
  output logic [CNT_W-1:0]   cnt_d
);

  logic               w_acc;
  logic [NUM_OUT-1:0] w_ld;
  logic [WIDTH-1:0]   w_q   [NUM_OUT];
  logic [CNT_W-1:0]   w_cnt [NUM_OUT];

  // Readiness looks only at the addressed slot, so a stalled channel never
  // blocks beats headed elsewhere. The slot can take a beat when it is empty
  // or is being drained this very cycle.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];

  // in_valid gates everything, so a floating in_sel while idle cannot reach
  // the slot valid flags.
  assign w_acc = in_valid & in_ready;
  assign w_ld  = {NUM_OUT{w_acc}} & sel_onehot(in_sel);

  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_slot
      demux_1_to_4_reg_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
      ) u_slot (
        .clk (clk),
        .rst (rst),
        .ld  (w_ld[gi]),
        .d   (in_data),
        .rdy (out_ready[gi]),
        .q   (w_q[gi]),
        .vld (out_valid[gi]),
        .cnt (w_cnt[gi])
      );
    end
  endgenerate

  assign out_a = w_q[CH_A];
  assign out_b = w_q[CH_B];
  assign out_c = w_q[CH_C];
  assign out_d = w_q[CH_D];

  assign cnt_a = w_cnt[CH_A];
  assign cnt_b = w_cnt[CH_B];
  assign cnt_c = w_cnt[CH_C];
  assign cnt_d = w_cnt[CH_D];

endmodule
`default_nettype wire

// File: tb/tb_demux_1_to_4_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_1_to_4_reg
//  Purpose  : Directed self-checking bench for demux_1_to_4_reg. Inputs are
//             driven 1ns after posedge, handshakes and in_ready are sampled on
//             the negedge, registered outputs 1ns after posedge. A reference
//             queue per channel holds the words expected at each drain.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1_to_4_reg;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_a, out_b, out_c, out_d;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c, cnt_d;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q_a[$];
  logic [WIDTH-1:0] q_b[$];
  logic [WIDTH-1:0] q_c[$];
  logic [WIDTH-1:0] q_d[$];

  always #5 clk = ~clk;

  demux_1_to_4_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
    .cnt_c     (cnt_c),
    .cnt_d     (cnt_d)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] ch, input logic [WIDTH-1:0] w);
    case (ch)
      2'd0: q_a.push_back(w);
      2'd1: q_b.push_back(w);
      2'd2: q_c.push_back(w);
      default: q_d.push_back(w);
    endcase
  endtask

  task automatic drain_one(input int ch, input logic [WIDTH-1:0] obs);
    int               n;
    logic [WIDTH-1:0] exp;
    exp = '0;
    case (ch)
      0: begin n = q_a.size(); if (n > 0) exp = q_a.pop_front(); end
      1: begin n = q_b.size(); if (n > 0) exp = q_b.pop_front(); end
      2: begin n = q_c.size(); if (n > 0) exp = q_c.pop_front(); end
      default: begin n = q_d.size(); if (n > 0) exp = q_d.pop_front(); end
    endcase
    if (n == 0) begin
      checks++;
      errors++;
      $error("FAIL drain_ch%0d observed=%0h expected=no_beat", ch, obs);
    end else begin
      check($sformatf("drain_ch%0d", ch), 32'(obs), 32'(exp));
    end
  endtask

  // Compare every out_valid&out_ready handshake that will happen at the
  // coming posedge against the reference queue.
  task automatic monitor();
    if (!rst) begin
      if (out_valid[0] === 1'b1 && out_ready[0]) drain_one(0, out_a);
      if (out_valid[1] === 1'b1 && out_ready[1]) drain_one(1, out_b);
      if (out_valid[2] === 1'b1 && out_ready[2]) drain_one(2, out_c);
      if (out_valid[3] === 1'b1 && out_ready[3]) drain_one(3, out_d);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for a single cycle; exp_rdy is the hand-computed in_ready.
  task automatic send(input logic [WIDTH-1:0] d, input logic [1:0] s, input logic exp_rdy,
                      input bit chk_rdy = 1'b1);
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    @(negedge clk);
    if (chk_rdy) check($sformatf("in_ready_sel%0d", s), 32'(in_ready), 32'(exp_rdy));
    monitor();
    if (exp_rdy) push(s, d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic clear_queues();
    q_a.delete();
    q_b.delete();
    q_c.delete();
    q_d.delete();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_out_a"}, 32'(out_a), 32'h0);
    check({tag, "_out_b"}, 32'(out_b), 32'h0);
    check({tag, "_out_c"}, 32'(out_c), 32'h0);
    check({tag, "_out_d"}, 32'(out_d), 32'h0);
    check({tag, "_cnt_a"}, 32'(cnt_a), 32'h0);
    check({tag, "_cnt_b"}, 32'(cnt_b), 32'h0);
    check({tag, "_cnt_c"}, 32'(cnt_c), 32'h0);
    check({tag, "_cnt_d"}, 32'(cnt_d), 32'h0);
  endtask

  initial begin
    // ---- reset ----
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = 2'd0;
    out_ready = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_cleared("reset");

    // ---- sweep: one word per channel, consumers always ready ----
    send(4'h0, 2'd0, 1'b1);
    check("sweep_a_data", 32'(out_a), 32'h0);
    check("sweep_a_vld", 32'(out_valid), 32'b0001);
    send(4'h1, 2'd1, 1'b1);
    check("sweep_b_data", 32'(out_b), 32'h1);
    check("sweep_b_vld", 32'(out_valid), 32'b0010);
    send(4'h2, 2'd2, 1'b1);
    check("sweep_c_data", 32'(out_c), 32'h2);
    check("sweep_c_vld", 32'(out_valid), 32'b0100);
    send(4'h3, 2'd3, 1'b1);
    check("sweep_d_data", 32'(out_d), 32'h3);
    check("sweep_d_vld", 32'(out_valid), 32'b1000);
    idle();
    check("sweep_drained", 32'(out_valid), 32'h0);
    check("sweep_cnts", {cnt_a, cnt_b, cnt_c, cnt_d}, 32'h01010101);

    // ---- stall isolation: channel b blocked ----
    out_ready = 4'b1101;
    send(4'h5, 2'd1, 1'b1);
    check("stall_b_first", 32'(out_b), 32'h5);
    send(4'h6, 2'd1, 1'b0);
    check("stall_b_hold", 32'(out_b), 32'h5);
    check("stall_b_cnt", 32'(cnt_b), 32'd2);
    send(4'h9, 2'd2, 1'b1);
    check("stall_c_data", 32'(out_c), 32'h9);
    check("stall_vld", 32'(out_valid), 32'b0110);
    check("stall_c_cnt", 32'(cnt_c), 32'd2);

    // ---- drain + refill of b; c drains in the same cycle ----
    out_ready = 4'b1111;
    send(4'h7, 2'd1, 1'b1);
    check("refill_vld", 32'(out_valid), 32'b0010);
    check("refill_b_data", 32'(out_b), 32'h7);
    check("refill_b_cnt", 32'(cnt_b), 32'd3);
    idle();
    check("refill_drained", 32'(out_valid), 32'h0);

    // ---- counter wrap on d: cnt_d starts at 1, 255 more beats wrap to 0 ----
    for (int i = 0; i < 255; i++) begin
      send(4'(i), 2'd3, 1'b1, i < 2);
      if (i == 253) check("wrap_d_max", 32'(cnt_d), 32'd255);
    end
    check("wrap_d_cnt", 32'(cnt_d), 32'd0);
    check("wrap_d_data", 32'(out_d), 32'hE);
    check("wrap_d_vld", 32'(out_valid), 32'b1000);
    idle();

    // ---- reset mid-stream with b and c stalled ----
    out_ready = 4'b1001;
    send(4'h3, 2'd1, 1'b1);
    send(4'h4, 2'd2, 1'b1);
    check("mid_vld", 32'(out_valid), 32'b0110);
    rst = 1'b1;
    clear_queues();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_cleared("midrst");
    out_ready = 4'b1111;
    send(4'hA, 2'd0, 1'b1);
    check("post_rst_a_data", 32'(out_a), 32'hA);
    check("post_rst_vld", 32'(out_valid), 32'b0001);
    check("post_rst_a_cnt", 32'(cnt_a), 32'd1);
    idle();
    check("post_rst_drained", 32'(out_valid), 32'h0);

    check("queues_empty", 32'(q_a.size() + q_b.size() + q_c.size() + q_d.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
